// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared constants and state encoding for the instruction-fetch stage
package instr_fetch_pkg;

  localparam int INSTR_W  = 16;
  localparam int TYPE_MSB = 15;
  localparam int TYPE_LSB = 13;
  localparam int OP_MSB   = 12;
  localparam int OP_LSB   = 8;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    BACKOFF = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction-memory request/acknowledge bus
interface instr_fetch_if #(
  parameter int ADDR_W = 16
);
  import instr_fetch_pkg::*;

  logic               IM_REQ;
  logic [ADDR_W-1:0]  IM_ADDR;
  logic               IM_ACK;
  logic [INSTR_W-1:0] IM_DATA;

  modport master (output IM_REQ, output IM_ADDR, input IM_ACK, input IM_DATA);
  modport slave  (input IM_REQ, input IM_ADDR, output IM_ACK, output IM_DATA);

endinterface

// File: rtl/instr_fetch_watchdog.sv
// rtl/instr_fetch_watchdog.sv - fetch timeout counter with sticky error flag
module fetch_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic CLK,
  input  logic RESET,
  input  logic active,
  input  logic ack,
  output logic expire,
  output logic FETCH_ERR
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  // An ACK on the final wait cycle takes priority over the timeout.
  assign expire = active && !ack && (count == LAST);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      count     <= '0;
      FETCH_ERR <= 1'b0;
    end else begin
      if ((active && ack) || expire) begin
        count <= '0;
      end else if (active) begin
        count <= count + 8'd1;
      end
      if (expire) begin
        FETCH_ERR <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter, instruction register and fetch FSM
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 TIMEOUT  = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               W_PC,
  input  logic               TAKEN,
  input  logic [ADDR_W-1:0]  JUMP_ADDR,
  instr_fetch_if.master      im,
  output logic [INSTR_W-1:0] IR,
  output logic [2:0]         ir_type,
  output logic [4:0]         op,
  output logic               IR_VALID,
  output logic [ADDR_W-1:0]  PC,
  output logic [ADDR_W-1:0]  PC_NEXT,
  output logic               FETCH_ERR
);

  fetch_state_t state, state_nxt;
  logic         fetch_req;
  logic         capture;
  logic         commit;
  logic         expire;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (im.IM_ACK) begin
          state_nxt = HOLD;
        end else if (expire) begin
          state_nxt = BACKOFF;
        end
      end
      HOLD: begin
        if (W_PC) begin
          state_nxt = FETCH;
        end
      end
      BACKOFF: state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // Reset leaves the state at FETCH, so the request must also be gated by RESET itself.
  always_comb begin
    fetch_req = (state == FETCH) && RESET;
    capture   = (state == FETCH) && im.IM_ACK;
    commit    = (state == HOLD) && W_PC;
  end

  fetch_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .CLK      (CLK),
    .RESET    (RESET),
    .active   (state == FETCH),
    .ack      (im.IM_ACK),
    .expire   (expire),
    .FETCH_ERR(FETCH_ERR)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      PC       <= RESET_PC;
      IR       <= '0;
      IR_VALID <= 1'b0;
    end else begin
      if (capture) begin
        IR       <= im.IM_DATA;
        IR_VALID <= 1'b1;
      end
      if (commit) begin
        PC       <= TAKEN ? JUMP_ADDR : PC_NEXT;
        IR_VALID <= 1'b0;
      end
    end
  end

  assign PC_NEXT    = PC + ADDR_W'(1);
  assign im.IM_REQ  = fetch_req;
  assign im.IM_ADDR = PC;
  assign ir_type    = IR[TYPE_MSB:TYPE_LSB];
  assign op         = IR[OP_MSB:OP_LSB];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - randomized self-checking bench for instr_fetch
module tb_instr_fetch;

  localparam int TIMEOUT = 15;

  logic        CLK;
  logic        RESET;
  logic        W_PC;
  logic        TAKEN;
  logic [15:0] JUMP_ADDR;
  logic [15:0] IR;
  logic [2:0]  ir_type;
  logic [4:0]  op;
  logic        IR_VALID;
  logic [15:0] PC;
  logic [15:0] PC_NEXT;
  logic        FETCH_ERR;

  instr_fetch_if #(.ADDR_W(16)) im ();

  instr_fetch #(
    .ADDR_W  (16),
    .RESET_PC(16'h0010),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .W_PC     (W_PC),
    .TAKEN    (TAKEN),
    .JUMP_ADDR(JUMP_ADDR),
    .im       (im),
    .IR       (IR),
    .ir_type  (ir_type),
    .op       (op),
    .IR_VALID (IR_VALID),
    .PC       (PC),
    .PC_NEXT  (PC_NEXT),
    .FETCH_ERR(FETCH_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks   = 0;
  int failures = 0;

  // Behavioural model: instruction held / backoff pending / cycles waited on the current request.
  logic [15:0] m_pc, m_ir;
  bit          m_valid, m_err, m_backoff;
  int          m_wait;

  // Memory environment controls.
  int next_delay = 0;
  int delay_q    = 0;
  bit req_active = 0;
  bit force_ack  = 0;
  bit rand_mode  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'h2A35;
    return {a[7:0], a[15:8]} ^ 16'hA5C3;
  endfunction

  function automatic bit m_req();
    return RESET && !m_valid && !m_backoff;
  endfunction

  function automatic int rand_delay();
    int r;
    r = int'($urandom_range(0, 15));
    if (r < 10) return int'($urandom_range(0, 3));
    if (r < 13) return TIMEOUT - 1;
    return 100;
  endfunction

  task automatic model_reset();
    m_pc      = 16'h0010;
    m_ir      = 16'h0000;
    m_valid   = 0;
    m_err     = 0;
    m_backoff = 0;
    m_wait    = 0;
  endtask

  task automatic model_update();
    if (!RESET) return;
    if (m_backoff) begin
      m_backoff = 0;
    end else if (!m_valid) begin
      if (im.IM_ACK) begin
        m_ir    = im.IM_DATA;
        m_valid = 1;
        m_wait  = 0;
      end else begin
        m_wait++;
        if (m_wait == TIMEOUT) begin
          m_err     = 1;
          m_wait    = 0;
          m_backoff = 1;
        end
      end
    end else if (W_PC) begin
      m_pc    = TAKEN ? JUMP_ADDR : m_pc + 16'd1;
      m_valid = 0;
    end
  endtask

  task automatic drive(input logic rst, input logic w, input logic t, input logic [15:0] j);
    RESET = rst;
    if (!rst) model_reset();
    W_PC      = w;
    TAKEN     = t;
    JUMP_ADDR = j;
    if (m_req()) begin
      if (!req_active) begin
        req_active = 1;
        delay_q    = (next_delay >= 0) ? next_delay : rand_delay();
      end
      im.IM_ACK  = (m_wait >= delay_q);
      im.IM_DATA = mem_word(m_pc);
    end else begin
      req_active = 0;
      if (force_ack) begin
        im.IM_ACK  = 1'b1;
        im.IM_DATA = 16'hBEEF;
      end else if (rand_mode && $urandom_range(0, 3) == 0) begin
        im.IM_ACK  = 1'b1;
        im.IM_DATA = 16'($urandom);
      end else begin
        im.IM_ACK  = 1'b0;
        im.IM_DATA = 16'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  always @(negedge CLK) begin
    logic [15:0] nx;
    nx = m_pc + 16'd1;
    chk("im_req",    32'(im.IM_REQ),  32'(m_req()));
    chk("im_addr",   32'(im.IM_ADDR), 32'(m_pc));
    chk("pc",        32'(PC),         32'(m_pc));
    chk("pc_next",   32'(PC_NEXT),    32'(nx));
    chk("ir",        32'(IR),         32'(m_ir));
    chk("ir_type",   32'(ir_type),    32'(m_ir[15:13]));
    chk("op",        32'(op),         32'(m_ir[12:8]));
    chk("ir_valid",  32'(IR_VALID),   32'(m_valid));
    chk("fetch_err", 32'(FETCH_ERR),  32'(m_err));
  end

  initial begin
    W_PC = 0; TAKEN = 0; JUMP_ADDR = 0;
    im.IM_ACK = 0; im.IM_DATA = 0;

    // Reset state.
    drive(0, 0, 0, 16'h0);
    tick();
    drive(0, 0, 0, 16'h0);
    tick();
    chk("rst_req", 32'(im.IM_REQ), 32'd0);
    chk("rst_pc",  32'(PC),        32'h0010);
    chk("rst_ir",  32'(IR),        32'h0);
    chk("rst_err", 32'(FETCH_ERR), 32'd0);

    // Zero-wait fetch at RESET_PC.
    next_delay = 0;
    drive(1, 0, 0, 16'h0);
    #1;
    chk("first_req",  32'(im.IM_REQ),  32'd1);
    chk("first_addr", 32'(im.IM_ADDR), 32'h0010);
    tick();
    chk("first_valid", 32'(IR_VALID), 32'd1);
    chk("first_ir",    32'(IR),       32'h2A35);
    chk("first_type",  32'(ir_type),  32'b001);
    chk("first_op",    32'(op),       32'b01010);
    chk("first_pcnx",  32'(PC_NEXT),  32'h0011);

    // Jump to 0xFFFF, then sequential wrap to 0.
    drive(1, 1, 1, 16'hFFFF);
    tick();
    chk("jmp_ffff_addr",  32'(im.IM_ADDR), 32'hFFFF);
    chk("jmp_ffff_valid", 32'(IR_VALID),   32'd0);
    drive(1, 0, 0, 16'h0);
    tick();
    drive(1, 1, 0, 16'h0BAD);
    tick();
    chk("wrap_addr",  32'(im.IM_ADDR), 32'h0000);
    chk("wrap_valid", 32'(IR_VALID),   32'd0);
    chk("wrap_pcnx",  32'(PC_NEXT),    32'h0001);
    drive(1, 0, 0, 16'h0);
    tick();

    // Jump to 0x1234, 3 wait states, stray W_PC during FETCH.
    next_delay = 3;
    drive(1, 1, 1, 16'h1234);
    tick();
    chk("jmp_addr", 32'(im.IM_ADDR), 32'h1234);
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 1), 1, 16'h5555);
      #1;
      chk("ws_req",  32'(im.IM_REQ),  32'd1);
      chk("ws_addr", 32'(im.IM_ADDR), 32'h1234);
      tick();
    end
    chk("ws_pc",    32'(PC),        32'h1234);
    chk("ws_valid", 32'(IR_VALID),  32'd1);
    chk("ws_ir",    32'(IR),        32'h91D1);
    chk("ws_err",   32'(FETCH_ERR), 32'd0);

    // ACK on the final wait cycle beats the timeout.
    next_delay = TIMEOUT - 1;
    drive(1, 1, 0, 16'h0);
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(1, 0, 0, 16'h0);
      tick();
    end
    chk("ackwin_valid", 32'(IR_VALID),  32'd1);
    chk("ackwin_err",   32'(FETCH_ERR), 32'd0);

    // Memory never answers: timeout, one backoff cycle, retry same address.
    next_delay = 100;
    drive(1, 1, 0, 16'h0);
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(1, 0, 0, 16'h0);
      #1;
      chk("to_req",    32'(im.IM_REQ), 32'd1);
      chk("to_noerr",  32'(FETCH_ERR), 32'd0);
      tick();
    end
    chk("to_err",     32'(FETCH_ERR),  32'd1);
    chk("to_backoff", 32'(im.IM_REQ),  32'd0);
    next_delay = 2;
    drive(1, 0, 0, 16'h0);
    tick();
    chk("retry_req",  32'(im.IM_REQ),  32'd1);
    chk("retry_addr", 32'(im.IM_ADDR), 32'h1236);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 16'h0);
      tick();
    end
    chk("retry_valid", 32'(IR_VALID),  32'd1);
    chk("retry_ir",    32'(IR),        32'h93D1);
    chk("retry_err",   32'(FETCH_ERR), 32'd1);

    // Reset during a wait state with an ACK arriving under reset.
    next_delay = 100;
    drive(1, 1, 0, 16'h0);
    tick();
    drive(1, 0, 0, 16'h0);
    tick();
    drive(1, 0, 0, 16'h0);
    tick();
    force_ack = 1;
    drive(0, 0, 0, 16'h0);
    #1;
    chk("mrst_req", 32'(im.IM_REQ), 32'd0);
    chk("mrst_ir",  32'(IR),        32'h0);
    tick();
    chk("mrst_ir2",   32'(IR),       32'h0);
    chk("mrst_valid", 32'(IR_VALID), 32'd0);
    force_ack  = 0;
    next_delay = 0;
    drive(1, 0, 0, 16'h0);
    #1;
    chk("mrel_req",  32'(im.IM_REQ),  32'd1);
    chk("mrel_addr", 32'(im.IM_ADDR), 32'h0010);
    chk("mrel_err",  32'(FETCH_ERR),  32'd0);
    tick();
    chk("mrel_ir", 32'(IR), 32'h2A35);

    // Randomized traffic.
    rand_mode  = 1;
    next_delay = -1;
    for (int i = 0; i < 4000; i++) begin
      logic r, w, t;
      logic [15:0] j;
      r = ($urandom_range(0, 299) != 0);
      w = m_valid ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
      t = 1'($urandom_range(0, 1));
      j = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      drive(r, w, t, j);
      tick();
    end

    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage feeding the multi-cycle control unit: holds the program counter, requests instruction words from instruction memory over a req/ack handshake, latches them in an instruction register, and presents the decoded `type`/`op` fields plus a valid flag to the control unit. The PC advances only on the control unit's write-back `W_PC` strobe, selecting either a sequential or a jump/branch target. The block includes a fetch watchdog that flags a memory that never acknowledges.

## Interface
Parameters:
- `ADDR_W`, 16: PC / instruction-memory word-address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `TIMEOUT`, 15: cycles without `IM_ACK` before a fetch is aborted and retried; legal range 1 to 255.

Ports:
- `CLK`  in  1  single clock; all state updates on rising edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `W_PC`  in  1  one-cycle PC-commit strobe from the control unit, asserted in its WB state.
- `TAKEN`  in  1  branch/jump condition from the flag-test unit; sampled only with `W_PC`.
- `JUMP_ADDR`  in  ADDR_W  target address; sampled only with `W_PC` and `TAKEN`.
- `IM_REQ`  out  1  fetch request to instruction memory.
- `IM_ADDR`  out  ADDR_W  fetch address; equals PC.
- `IM_ACK`  in  1  memory acknowledge; `IM_DATA` is valid in the same cycle.
- `IM_DATA`  in  16  instruction word.
- `IR`  out  16  instruction register.
- `type`  out  3  `IR[15:13]`.
- `op`  out  5  `IR[12:8]`.
- `IR_VALID`  out  1  `IR` holds the instruction at the current PC; the control unit stays in IF while this is low.
- `PC`  out  ADDR_W  current PC.
- `PC_NEXT`  out  ADDR_W  PC+1 modulo 2^ADDR_W, used as the jal link value.
- `FETCH_ERR`  out  1  sticky watchdog flag.

## Operation
- States: `FETCH`, `HOLD`, `BACKOFF`.
- Reset (asynchronous, `RESET`=0):
  - PC=`RESET_PC`, IR=0, `IR_VALID`=0, `FETCH_ERR`=0, watchdog count=0, state=`FETCH`.
  - `IM_REQ` is forced to 0 while `RESET` is low.
- `FETCH`: `IM_REQ`=1 and `IM_ADDR`=PC.
  - `IM_ACK`=1 at a clock edge: IR←`IM_DATA`, `IR_VALID`←1, count←0, go to `HOLD`.
  - Otherwise count←count+1.
  - count reaches `TIMEOUT`: `FETCH_ERR`←1, count←0, go to `BACKOFF`.
- `BACKOFF`: `IM_REQ`=0 for exactly one cycle, then return to `FETCH` at the same PC.
- `HOLD`: `IM_REQ`=0; IR and PC are stable.
  - On `W_PC`: PC←`TAKEN` ? `JUMP_ADDR` : `PC_NEXT`; `IR_VALID`←0; go to `FETCH`.
- `W_PC` outside `HOLD` is ignored: no PC change, no state change.
- `IM_ACK` outside `FETCH` is ignored; IR is never overwritten while in `HOLD`.
- PC arithmetic is ADDR_W-bit unsigned and wraps from 2^ADDR_W−1 to 0. `JUMP_ADDR` is loaded verbatim.
- `FETCH_ERR` is cleared only by reset. Fetching continues normally after it is set.
- `type`, `op`, `IM_ADDR` and `PC_NEXT` are combinational from registers only; no input-to-output combinational paths.

## Timing
- `IM_REQ` is decoded from the state register, so it goes high in the first cycle of `FETCH`.
- A zero-wait-state memory (ACK in that same cycle) gives `IR_VALID`=1 one cycle later.
- `W_PC` edge to new `IM_ADDR`: 1 cycle.
- `W_PC` edge to `IR_VALID` for the new instruction: minimum 2 cycles.
- With N wait cycles (N < `TIMEOUT`), `IR_VALID` rises N+1 cycles after `IM_REQ` rises.
- Once `IM_REQ` is raised, it and `IM_ADDR` stay stable until the ACK edge, or until the timeout edge.
- Simultaneous ACK and count reaching `TIMEOUT`: ACK wins. The instruction is captured and `FETCH_ERR` is not set.
- Reset asserted mid-fetch: the request drops immediately; any late ACK is ignored until after reset deassertion. The first fetch after release is at `RESET_PC`.

## Structure
- Shared package:
  - state encoding;
  - IR field positions (`TYPE_MSB`=15, `TYPE_LSB`=13, `OP_MSB`=12, `OP_LSB`=8);
  - instruction word width constant (16).
- One sub-module is natural: `fetch_watchdog`, holding the count, the compare to `TIMEOUT`, and the sticky error flag. PC, IR and the FSM stay in the top.

## Test plan
- Reset release with `RESET_PC`=0x0010, memory ACKs immediately with 0x2A35 → `IM_ADDR`=0x0010; `IR_VALID`=1 next cycle; `type`=3'b001; `op`=5'b01010; `PC_NEXT`=0x0011.
- `W_PC`=1 with `TAKEN`=0 at PC=0xFFFF (ADDR_W=16) → next `IM_ADDR`=0x0000; `IR_VALID` drops for at least 1 cycle.
- `W_PC`=1 with `TAKEN`=1 and `JUMP_ADDR`=0x1234 → `IM_ADDR`=0x1234; a stray `W_PC` during the following `FETCH` leaves PC at 0x1234.
- Memory with 3 wait states → `IM_REQ` and `IM_ADDR` stable for 4 cycles; IR captured on the ACK edge; `FETCH_ERR` stays 0.
- Memory never ACKs with `TIMEOUT`=15 → `FETCH_ERR`=1 after 15 request cycles; `IM_REQ` low for 1 cycle, then re-requests the same address. A later ACK is captured normally and `FETCH_ERR` stays 1.
- Reset asserted during a wait state, with ACK arriving while `RESET`=0 → IR stays 0 and `IM_REQ`=0. After release, the fetch restarts at `RESET_PC` with `FETCH_ERR`=0.
